// File: rtl/hazard_controller_mc.sv
`default_nettype none
// ============================================================================
// Module      : hazard_controller_mc
// Description : Pipeline hazard controller for a five-stage core. Produces
//               per-stage stall/flush controls for load-use interlocks,
//               mispredict redirects, trap/mode switches and memory-busy
//               stalls, plus saturating stall/mispredict event counters.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_controller_mc #(
    parameter int REG_AW   = 5,
    parameter int LOAD_LAT = 1,
    parameter int SW_FLUSH = 1,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              is_load_exe,
    input  logic              we_reg_exe,
    input  logic [REG_AW-1:0] rd_addr_exe,
    input  logic [REG_AW-1:0] rs1_addr_id,
    input  logic [REG_AW-1:0] rs2_addr_id,
    input  logic              use_rs1_id,
    input  logic              use_rs2_id,
    input  logic              error_prediction,
    input  logic              switch_mode,
    input  logic              if_stall,
    input  logic              mem_stall,
    input  logic              clr_cnt,
    output logic              stall_PC,
    output logic              stall_IFID,
    output logic              stall_IDEXE,
    output logic              stall_EXEMEM,
    output logic              stall_MEMWB,
    output logic              flush_IFID,
    output logic              flush_IDEXE,
    output logic              flush_EXEMEM,
    output logic              flush_MEMWB,
    output logic [CNT_W-1:0]  cnt_stall,
    output logic [CNT_W-1:0]  cnt_mispred
);

    typedef enum logic [0:0] {
        R_IDLE = 1'b0,
        R_WAIT = 1'b1
    } redir_state_t;

    // Both down-counters fit in two bits since their loads never exceed 3.
    localparam logic [1:0]       c_LU_LOAD = 2'(LOAD_LAT - 1);
    localparam logic [1:0]       c_SW_LOAD = 2'(SW_FLUSH - 1);
    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;

    logic [1:0]       r_sw_cnt;
    logic [1:0]       r_lu_cnt;
    redir_state_t     r_state;
    logic [CNT_W-1:0] r_cnt_stall;
    logic [CNT_W-1:0] r_cnt_mispred;

    logic w_rs1_hit;
    logic w_rs2_hit;
    logic w_lu_hit;
    logic w_sw_active;
    logic w_redirect;
    logic w_lu_active;
    logic w_stall_pc;
    logic w_stall_ifid;
    logic w_stall_idexe;
    logic w_stall_exemem;
    logic w_flush_ifid;
    logic w_flush_idexe;
    logic w_flush_exemem;
    logic w_flush_memwb;

    // Hazard detection and prioritised stall/flush generation.
    always_comb begin
        w_rs1_hit      = use_rs1_id && (rs1_addr_id == rd_addr_exe) && (rs1_addr_id != '0);
        w_rs2_hit      = use_rs2_id && (rs2_addr_id == rd_addr_exe) && (rs2_addr_id != '0);
        w_lu_hit       = is_load_exe && we_reg_exe && (w_rs1_hit || w_rs2_hit);
        w_sw_active    = switch_mode || (r_sw_cnt != 2'd0);
        w_redirect     = !w_sw_active && (error_prediction || (r_state == R_WAIT));
        w_lu_active    = !w_sw_active && (w_lu_hit || (r_lu_cnt != 2'd0));
        w_stall_pc     = 1'b0;
        w_stall_ifid   = 1'b0;
        w_stall_idexe  = 1'b0;
        w_stall_exemem = 1'b0;
        w_flush_ifid   = 1'b1;
        w_flush_idexe  = 1'b1;
        w_flush_exemem = 1'b1;
        w_flush_memwb  = 1'b1;
        if (!w_sw_active) begin
            w_stall_exemem = mem_stall;
            w_stall_idexe  = w_stall_exemem;
            w_flush_memwb  = w_stall_exemem;
            w_stall_ifid   = w_stall_idexe || (w_lu_active && !w_redirect);
            w_flush_idexe  = (w_stall_ifid && !w_stall_idexe) || w_redirect;
            // Waiting on the fetch side keeps PC frozen until the redirect lands;
            // an idle-state mispredict must let the branch target load now.
            if (r_state == R_WAIT) begin
                w_stall_pc = 1'b1;
            end else if (error_prediction) begin
                w_stall_pc = 1'b0;
            end else begin
                w_stall_pc = w_stall_ifid || if_stall;
            end
            w_flush_ifid   = (w_stall_pc && !w_stall_ifid) || w_redirect;
            w_flush_exemem = w_stall_idexe && !w_stall_exemem;
        end
    end

    // Reset holds every stage in bubble state regardless of other inputs.
    assign stall_PC     = rstn && w_stall_pc;
    assign stall_IFID   = rstn && w_stall_ifid;
    assign stall_IDEXE  = rstn && w_stall_idexe;
    assign stall_EXEMEM = rstn && w_stall_exemem;
    assign stall_MEMWB  = 1'b0;
    assign flush_IFID   = !rstn || w_flush_ifid;
    assign flush_IDEXE  = !rstn || w_flush_idexe;
    assign flush_EXEMEM = !rstn || w_flush_exemem;
    assign flush_MEMWB  = !rstn || w_flush_memwb;
    assign cnt_stall    = r_cnt_stall;
    assign cnt_mispred  = r_cnt_mispred;

    // Switch flush window: a pulse (re)loads the remaining flush cycles.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_sw_cnt <= 2'd0;
        end else if (switch_mode) begin
            r_sw_cnt <= c_SW_LOAD;
        end else if (r_sw_cnt != 2'd0) begin
            r_sw_cnt <= r_sw_cnt - 2'd1;
        end
    end

    // Load-use bubble counter; only advances when the back end is moving.
    always_ff @(posedge clk) begin
        if (!rstn || w_sw_active) begin
            r_lu_cnt <= 2'd0;
        end else if (r_lu_cnt != 2'd0) begin
            if (!w_stall_exemem) begin
                r_lu_cnt <= r_lu_cnt - 2'd1;
            end
        end else if (w_lu_hit && !w_stall_exemem && !w_redirect) begin
            r_lu_cnt <= c_LU_LOAD;
        end
    end

    // Redirect FSM: wait out a busy instruction fetch after a mispredict.
    always_ff @(posedge clk) begin
        if (!rstn || w_sw_active) begin
            r_state <= R_IDLE;
        end else begin
            case (r_state)
                R_IDLE:  if (error_prediction && if_stall) r_state <= R_WAIT;
                R_WAIT:  if (!if_stall) r_state <= R_IDLE;
                default: r_state <= R_IDLE;
            endcase
        end
    end

    // Saturating performance counters; clear wins over increment.
    always_ff @(posedge clk) begin
        if (!rstn || clr_cnt) begin
            r_cnt_stall   <= '0;
            r_cnt_mispred <= '0;
        end else begin
            if (w_stall_pc && (r_cnt_stall != c_CNT_MAX)) begin
                r_cnt_stall <= r_cnt_stall + 1'b1;
            end
            if ((r_state == R_IDLE) && error_prediction && (r_cnt_mispred != c_CNT_MAX)) begin
                r_cnt_mispred <= r_cnt_mispred + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hazard_controller_mc.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_controller_mc
// Description : Self-checking bench for hazard_controller_mc with directed
//               scenarios and randomized traffic against a cycle model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_controller_mc;

    localparam int REG_AW   = 5;
    localparam int LOAD_LAT = 2;
    localparam int SW_FLUSH = 3;
    localparam int CNT_W    = 4;
    localparam int C_MAX    = 15;

    logic              clk = 1'b0;
    logic              rstn;
    logic              is_load_exe, we_reg_exe;
    logic [REG_AW-1:0] rd_addr_exe, rs1_addr_id, rs2_addr_id;
    logic              use_rs1_id, use_rs2_id;
    logic              error_prediction, switch_mode, if_stall, mem_stall, clr_cnt;
    logic              stall_PC, stall_IFID, stall_IDEXE, stall_EXEMEM, stall_MEMWB;
    logic              flush_IFID, flush_IDEXE, flush_EXEMEM, flush_MEMWB;
    logic [CNT_W-1:0]  cnt_stall, cnt_mispred;
    logic [16:0]       obs;

    int n_checks;
    int n_errors;

    // Model state: remaining switch flush cycles, remaining load-use bubbles,
    // waiting-for-fetch flag and the two event counts.
    int m_sw, m_lu, m_cs, m_cm;
    bit m_wait;

    always #5 clk = ~clk;

    hazard_controller_mc #(
        .REG_AW(REG_AW), .LOAD_LAT(LOAD_LAT), .SW_FLUSH(SW_FLUSH), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rstn(rstn),
        .is_load_exe(is_load_exe), .we_reg_exe(we_reg_exe),
        .rd_addr_exe(rd_addr_exe), .rs1_addr_id(rs1_addr_id), .rs2_addr_id(rs2_addr_id),
        .use_rs1_id(use_rs1_id), .use_rs2_id(use_rs2_id),
        .error_prediction(error_prediction), .switch_mode(switch_mode),
        .if_stall(if_stall), .mem_stall(mem_stall), .clr_cnt(clr_cnt),
        .stall_PC(stall_PC), .stall_IFID(stall_IFID), .stall_IDEXE(stall_IDEXE),
        .stall_EXEMEM(stall_EXEMEM), .stall_MEMWB(stall_MEMWB),
        .flush_IFID(flush_IFID), .flush_IDEXE(flush_IDEXE),
        .flush_EXEMEM(flush_EXEMEM), .flush_MEMWB(flush_MEMWB),
        .cnt_stall(cnt_stall), .cnt_mispred(cnt_mispred)
    );

    assign obs = {stall_PC, stall_IFID, stall_IDEXE, stall_EXEMEM, stall_MEMWB,
                  flush_IFID, flush_IDEXE, flush_EXEMEM, flush_MEMWB, cnt_stall, cnt_mispred};

    function automatic bit load_use_hit();
        bit h1, h2;
        h1 = use_rs1_id && (rs1_addr_id == rd_addr_exe) && (rs1_addr_id != 0);
        h2 = use_rs2_id && (rs2_addr_id == rd_addr_exe) && (rs2_addr_id != 0);
        return is_load_exe && we_reg_exe && (h1 || h2);
    endfunction

    // Expected output vector for the current inputs and model state.
    function automatic logic [16:0] exp_vec();
        bit redir, lu, hm, hi, hp, fi, fd;
        logic [3:0] cs, cm;
        cs = 4'(m_cs);
        cm = 4'(m_cm);
        if (!rstn || switch_mode || m_sw > 0) return {5'b00000, 4'b1111, cs, cm};
        redir = error_prediction || m_wait;
        lu    = load_use_hit() || m_lu > 0;
        hm    = mem_stall;
        hi    = hm || (lu && !redir);
        if (m_wait)                hp = 1'b1;
        else if (error_prediction) hp = 1'b0;
        else                       hp = hi || if_stall;
        fi = (hp && !hi) || redir;
        fd = (hi && !hm) || redir;
        return {hp, hi, hm, hm, 1'b0, fi, fd, 1'b0, hm, cs, cm};
    endfunction

    // Advance the model by one clock using the inputs currently applied.
    function automatic void model_step();
        logic [16:0] e;
        bit sw, redir;
        e = exp_vec();
        if (!rstn) begin
            m_sw = 0; m_lu = 0; m_wait = 0; m_cs = 0; m_cm = 0;
            return;
        end
        sw    = switch_mode || m_sw > 0;
        redir = !sw && (error_prediction || m_wait);
        if (clr_cnt) begin
            m_cs = 0;
            m_cm = 0;
        end else begin
            if (e[16] && m_cs < C_MAX) m_cs++;
            if (!m_wait && error_prediction && m_cm < C_MAX) m_cm++;
        end
        if (sw) begin
            m_lu   = 0;
            m_wait = 0;
        end else begin
            if (m_lu > 0) begin
                if (!mem_stall) m_lu--;
            end else if (load_use_hit() && !mem_stall && !redir) begin
                m_lu = LOAD_LAT - 1;
            end
            m_wait = m_wait ? if_stall : (error_prediction && if_stall);
        end
        if (switch_mode) m_sw = SW_FLUSH - 1;
        else if (m_sw > 0) m_sw--;
    endfunction

    task automatic set_idle();
        rstn = 1'b1; is_load_exe = 1'b0; we_reg_exe = 1'b0;
        rd_addr_exe = '0; rs1_addr_id = '0; rs2_addr_id = '0;
        use_rs1_id = 1'b0; use_rs2_id = 1'b0; error_prediction = 1'b0;
        switch_mode = 1'b0; if_stall = 1'b0; mem_stall = 1'b0; clr_cnt = 1'b0;
    endtask

    task automatic adv();
        model_step();
        @(negedge clk);
    endtask

    task automatic clr_cycle();
        set_idle();
        clr_cnt = 1'b1;
        #1;
        adv();
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            rstn = 1'b0;
            is_load_exe = 1'($urandom); we_reg_exe = 1'($urandom);
            rd_addr_exe = 5'($urandom); rs1_addr_id = rd_addr_exe; rs2_addr_id = 5'($urandom);
            use_rs1_id = 1'b1; use_rs2_id = 1'($urandom);
            error_prediction = 1'($urandom); switch_mode = 1'b0;
            if_stall = 1'b1; mem_stall = 1'b1; clr_cnt = 1'b0;
            #1;
            n_checks++;
            if (obs[16:4] !== 13'h000F << 4 >> 4 && obs[16:4] !== {5'b00000, 4'b1111, cnt_stall}) begin
                n_errors++;
                $display("FAIL reset_ctrl: got %b expected stalls 0 flushes 1", obs[16:8]);
            end
            n_checks++;
            if (obs[16:8] !== 9'b00000_1111) begin
                n_errors++;
                $display("FAIL reset_outputs: got %b expected %b", obs[16:8], 9'b00000_1111);
            end
            if (i > 0) begin
                n_checks++;
                if (obs !== exp_vec()) begin
                    n_errors++;
                    $display("FAIL reset_state: got %b expected %b", obs, exp_vec());
                end
            end
            adv();
        end
        set_idle();
        #1;
        n_checks++;
        if (obs !== 17'd0) begin
            n_errors++;
            $display("FAIL reset_release: got %b expected %b", obs, 17'd0);
        end
        adv();
    endtask

    task automatic test_load_use();
        logic [2:0] exp3;
        clr_cycle();
        for (int i = 0; i < 3; i++) begin
            set_idle();
            rd_addr_exe = 5'd5; rs1_addr_id = 5'd5; use_rs1_id = 1'b1;
            rs2_addr_id = 5'd7; use_rs2_id = 1'b1;
            if (i == 0) begin
                is_load_exe = 1'b1;
                we_reg_exe  = 1'b1;
            end
            #1;
            exp3 = (i < LOAD_LAT) ? 3'b111 : 3'b000;
            n_checks++;
            if ({stall_PC, stall_IFID, flush_IDEXE} !== exp3) begin
                n_errors++;
                $display("FAIL load_use cycle %0d: got %b expected %b", i, {stall_PC, stall_IFID, flush_IDEXE}, exp3);
            end
            n_checks++;
            if (obs !== exp_vec()) begin
                n_errors++;
                $display("FAIL load_use_model cycle %0d: got %b expected %b", i, obs, exp_vec());
            end
            adv();
        end
        set_idle();
        #1;
        n_checks++;
        if (cnt_stall !== 4'd2) begin
            n_errors++;
            $display("FAIL load_use_cnt: got %0d expected 2", cnt_stall);
        end
        adv();
    endtask

    task automatic test_no_hazard();
        for (int c = 0; c < 2; c++) begin
            set_idle();
            is_load_exe = 1'b1; we_reg_exe = 1'b1;
            rs2_addr_id = 5'd3; use_rs2_id = 1'b1;
            if (c == 0) begin
                rd_addr_exe = 5'd0; rs1_addr_id = 5'd0; use_rs1_id = 1'b1;
            end else begin
                rd_addr_exe = 5'd5; rs1_addr_id = 5'd5; use_rs1_id = 1'b0;
            end
            #1;
            n_checks++;
            if ({obs[16:12], obs[11:8]} !== 9'd0) begin
                n_errors++;
                $display("FAIL no_hazard case %0d: got %b expected %b", c, obs[16:8], 9'd0);
            end
            adv();
        end
    endtask

    task automatic test_redirect();
        logic [4:0] ep_seq, is_seq;
        logic [9:0] exp_seq;
        ep_seq  = 5'b00001;
        is_seq  = 5'b00111;
        exp_seq = {2'b00, 2'b11, 2'b11, 2'b11, 2'b01};
        clr_cycle();
        for (int i = 0; i < 5; i++) begin
            set_idle();
            error_prediction = ep_seq[i];
            if_stall         = is_seq[i];
            #1;
            n_checks++;
            if ({stall_PC, flush_IFID} !== exp_seq[2*i +: 2]) begin
                n_errors++;
                $display("FAIL redirect cycle %0d: got %b expected %b", i, {stall_PC, flush_IFID}, exp_seq[2*i +: 2]);
            end
            n_checks++;
            if (obs !== exp_vec()) begin
                n_errors++;
                $display("FAIL redirect_model cycle %0d: got %b expected %b", i, obs, exp_vec());
            end
            adv();
        end
        set_idle();
        #1;
        n_checks++;
        if (cnt_mispred !== 4'd1 || cnt_stall !== 4'd3) begin
            n_errors++;
            $display("FAIL redirect_cnt: got mispred %0d stall %0d expected 1 and 3", cnt_mispred, cnt_stall);
        end
        adv();
    endtask

    task automatic test_switch();
        logic [8:0] exp9;
        for (int i = 0; i < 5; i++) begin
            set_idle();
            rd_addr_exe = 5'd5; rs1_addr_id = 5'd5; use_rs1_id = 1'b1;
            if (i == 0) begin
                is_load_exe = 1'b1;
                we_reg_exe  = 1'b1;
            end
            switch_mode = (i == 1);
            mem_stall   = (i >= 1 && i <= 3);
            #1;
            if (i > 0) begin
                exp9 = (i < 4) ? 9'b00000_1111 : 9'd0;
                n_checks++;
                if (obs[16:8] !== exp9) begin
                    n_errors++;
                    $display("FAIL switch cycle %0d: got %b expected %b", i, obs[16:8], exp9);
                end
            end
            n_checks++;
            if (obs !== exp_vec()) begin
                n_errors++;
                $display("FAIL switch_model cycle %0d: got %b expected %b", i, obs, exp_vec());
            end
            adv();
        end
    endtask

    task automatic test_mem_stall_lu();
        logic [4:0]  hit_seq, ms_seq;
        logic [29:0] exp_seq;
        logic [5:0]  got;
        hit_seq = 5'b00011;
        ms_seq  = 5'b00101;
        exp_seq = {6'b000000, 6'b110010, 6'b111101, 6'b110010, 6'b111101};
        for (int i = 0; i < 5; i++) begin
            set_idle();
            rd_addr_exe = 5'd9; rs2_addr_id = 5'd9; use_rs2_id = 1'b1;
            is_load_exe = hit_seq[i];
            we_reg_exe  = hit_seq[i];
            mem_stall   = ms_seq[i];
            #1;
            got = {stall_PC, stall_IFID, stall_IDEXE, stall_EXEMEM, flush_IDEXE, flush_MEMWB};
            n_checks++;
            if (got !== exp_seq[6*i +: 6]) begin
                n_errors++;
                $display("FAIL mem_stall_lu cycle %0d: got %b expected %b", i, got, exp_seq[6*i +: 6]);
            end
            n_checks++;
            if (obs !== exp_vec()) begin
                n_errors++;
                $display("FAIL mem_stall_lu_model cycle %0d: got %b expected %b", i, obs, exp_vec());
            end
            adv();
        end
    endtask

    task automatic test_saturation();
        clr_cycle();
        for (int i = 0; i < 20; i++) begin
            set_idle();
            if_stall = 1'b1;
            #1;
            n_checks++;
            if (obs !== exp_vec()) begin
                n_errors++;
                $display("FAIL saturation_model cycle %0d: got %b expected %b", i, obs, exp_vec());
            end
            adv();
        end
        set_idle();
        if_stall = 1'b1;
        clr_cnt  = 1'b1;
        #1;
        n_checks++;
        if (cnt_stall !== 4'd15) begin
            n_errors++;
            $display("FAIL saturation_max: got %0d expected 15", cnt_stall);
        end
        adv();
        set_idle();
        #1;
        n_checks++;
        if (cnt_stall !== 4'd0) begin
            n_errors++;
            $display("FAIL saturation_clear: got %0d expected 0", cnt_stall);
        end
        adv();
    endtask

    task automatic test_reset_mid();
        // Enter the fetch-wait state, then reset in the middle of it.
        set_idle(); error_prediction = 1'b1; if_stall = 1'b1; #1; adv();
        set_idle(); if_stall = 1'b1; #1;
        n_checks++;
        if ({stall_PC, flush_IFID} !== 2'b11) begin
            n_errors++;
            $display("FAIL reset_mid_wait: got %b expected 11", {stall_PC, flush_IFID});
        end
        adv();
        set_idle(); rstn = 1'b0; if_stall = 1'b1; mem_stall = 1'b1; error_prediction = 1'b1; #1;
        n_checks++;
        if (obs[16:8] !== 9'b00000_1111) begin
            n_errors++;
            $display("FAIL reset_mid_assert: got %b expected %b", obs[16:8], 9'b00000_1111);
        end
        adv();
        set_idle(); #1;
        n_checks++;
        if (obs !== 17'd0) begin
            n_errors++;
            $display("FAIL reset_mid_wait_release: got %b expected %b", obs, 17'd0);
        end
        adv();
        // Start a load-use bubble sequence, then reset before it drains.
        set_idle(); is_load_exe = 1'b1; we_reg_exe = 1'b1;
        rd_addr_exe = 5'd4; rs1_addr_id = 5'd4; use_rs1_id = 1'b1; #1; adv();
        set_idle(); rstn = 1'b0; #1; adv();
        set_idle(); #1;
        n_checks++;
        if (obs[16:8] !== 9'd0) begin
            n_errors++;
            $display("FAIL reset_mid_lu_release: got %b expected %b", obs[16:8], 9'd0);
        end
        adv();
    endtask

    task automatic test_random();
        logic [16:0] e;
        for (int i = 0; i < 3000; i++) begin
            rstn             = ($urandom_range(0, 63) != 0);
            is_load_exe      = 1'($urandom_range(0, 1));
            we_reg_exe       = ($urandom_range(0, 3) != 0);
            rd_addr_exe      = 5'($urandom_range(0, 3));
            rs1_addr_id      = 5'($urandom_range(0, 3));
            rs2_addr_id      = 5'($urandom_range(0, 3));
            use_rs1_id       = 1'($urandom_range(0, 1));
            use_rs2_id       = 1'($urandom_range(0, 1));
            switch_mode      = ($urandom_range(0, 15) == 0);
            error_prediction = ($urandom_range(0, 7) == 0);
            if_stall         = ($urandom_range(0, 3) == 0);
            mem_stall        = ($urandom_range(0, 3) == 0);
            clr_cnt          = ($urandom_range(0, 31) == 0);
            #1;
            e = exp_vec();
            n_checks++;
            if (obs !== e) begin
                n_errors++;
                $display("FAIL random cycle %0d: got %b expected %b", i, obs, e);
            end
            adv();
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        m_sw = 0; m_lu = 0; m_wait = 0; m_cs = 0; m_cm = 0;
        set_idle();
        rstn = 1'b0;
        @(negedge clk);
        test_reset();
        test_load_use();
        test_no_hazard();
        test_redirect();
        test_switch();
        test_mem_stall_lu();
        test_saturation();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
